// File: rtl/serial_cmp_tx.sv
// serial_cmp_tx: bit-serial unsigned magnitude comparator front end.
// Latches a/b on start, shifts them out MSB-first one pair per cycle,
// and accumulates eq/gt/lt; results are held until the next DONE.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   start             begin a comparison (accepted in IDLE or DONE)
//   a, b              WIDTH-bit operands, latched on accepted start
//   busy              high during SHIFT
//   bit_valid         bit_a/bit_b/bit_idx carry an operand bit
//   bit_a, bit_b      current serial bits, MSB first
//   bit_idx           index of the bit being presented
//   done              one-cycle pulse when eq/gt/lt update
//   eq, gt, lt        registered, held comparison result
module serial_cmp_tx #(
    parameter  int WIDTH = 4,
    localparam int IW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             bit_valid,
    output logic             bit_a,
    output logic             bit_b,
    output logic [IW-1:0]    bit_idx,
    output logic             done,
    output logic             eq,
    output logic             gt,
    output logic             lt
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t state;
    state_t state_nx;

    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [IW-1:0]    idx;
    logic             acc_eq;
    logic             acc_gt;
    logic             acc_lt;
    logic             decided;

    logic load;
    logic last_bit;
    logic sa;
    logic sb;
    logic e;
    logic hit;
    logic nx_eq;
    logic nx_gt;
    logic nx_lt;

    assign sa       = a_reg[idx];
    assign sb       = b_reg[idx];
    assign last_bit = (idx == '0);

    // First differing bit from the MSB decides; later pairs are ignored.
    assign e     = (sa & sb) | (~sa & ~sb);
    assign hit   = ~e & ~decided;
    assign nx_eq = hit ? 1'b0      : acc_eq;
    assign nx_gt = hit ? sa & ~sb  : acc_gt;
    assign nx_lt = hit ? ~sa & sb  : acc_lt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        load      = 1'b0;
        busy      = 1'b0;
        bit_valid = 1'b0;
        bit_a     = 1'b0;
        bit_b     = 1'b0;
        bit_idx   = '0;
        done      = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    load     = 1'b1;
                    state_nx = SHIFT;
                end
            end
            SHIFT: begin
                busy      = 1'b1;
                bit_valid = 1'b1;
                bit_a     = sa;
                bit_b     = sb;
                bit_idx   = idx;
                if (last_bit) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                done     = 1'b1;
                load     = start;
                state_nx = start ? SHIFT : IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_reg   <= '0;
            b_reg   <= '0;
            idx     <= '0;
            acc_eq  <= 1'b0;
            acc_gt  <= 1'b0;
            acc_lt  <= 1'b0;
            decided <= 1'b0;
            eq      <= 1'b0;
            gt      <= 1'b0;
            lt      <= 1'b0;
        end else if (load) begin
            a_reg   <= a;
            b_reg   <= b;
            idx     <= IW'(WIDTH - 1);
            acc_eq  <= 1'b1;
            acc_gt  <= 1'b0;
            acc_lt  <= 1'b0;
            decided <= 1'b0;
        end else if (state == SHIFT) begin
            acc_eq  <= nx_eq;
            acc_gt  <= nx_gt;
            acc_lt  <= nx_lt;
            decided <= decided | hit;
            if (last_bit) begin
                // Publish including the LSB pair's update.
                eq <= nx_eq;
                gt <= nx_gt;
                lt <= nx_lt;
            end else begin
                idx <= idx - 1'b1;
            end
        end
    end

endmodule

// File: doc/serial_cmp_tx.md
Name: serial_cmp_tx

Overview:
- Bit-serial magnitude comparator front end for the Basys 3 ALU.
- Latches two WIDTH-bit operands on a start pulse, then transmits them MSB-first as one bit pair per cycle.
- Evaluates each bit pair with per-bit equality logic and accumulates eq/gt/lt across the stream.
- Sits between the operand registers (switches) and the ALU result mux, and exports the serial bit stream for the LEDs/debug.

Parameters:
- WIDTH, 4, operand width in bits; legal range is 2 or more.

Ports:
- clk  input  1  system clock
- rst_n  input  1  synchronous active-low reset
- start  input  1  begin a comparison; sampled only in IDLE or DONE
- a  input  WIDTH  operand A, latched on accepted start
- b  input  WIDTH  operand B, latched on accepted start
- busy  output  1  high while a comparison is in progress (SHIFT state)
- bit_valid  output  1  bit_a/bit_b carry a valid operand bit this cycle
- bit_a  output  1  current serial bit of A, MSB first
- bit_b  output  1  current serial bit of B, MSB first
- bit_idx  output  clog2(WIDTH)  index of the bit currently presented
- done  output  1  single-cycle pulse when results update
- eq  output  1  A == B (registered, held)
- gt  output  1  A > B unsigned (registered, held)
- lt  output  1  A < B unsigned (registered, held)

Behaviour:
- Reset: clk is the only clock; reset is synchronous and active-low on rst_n.
  - While rst_n is low at a clk edge: state <= IDLE.
  - All outputs are 0: busy, bit_valid, bit_a, bit_b, bit_idx, done, eq, gt, lt.
  - Internal operand registers and accumulators are cleared.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 causes the following at the next edge:
    - a_reg <= a, b_reg <= b, idx <= WIDTH-1.
    - acc_eq <= 1, acc_gt <= 0, acc_lt <= 0, decided <= 0.
    - State -> SHIFT.
  - start=0: stay in IDLE.
- SHIFT:
  - Outputs this cycle: busy=1, bit_valid=1, bit_a=a_reg[idx], bit_b=b_reg[idx], bit_idx=idx.
  - Per-bit equality: e = (bit_a & bit_b) | (~bit_a & ~bit_b).
  - If e=0 and decided=0:
    - decided <= 1, acc_eq <= 0.
    - acc_gt <= bit_a & ~bit_b, acc_lt <= ~bit_a & bit_b.
  - Once decided=1, later bit pairs do not change the accumulators (the first differing bit from the MSB wins).
  - idx=0: state -> DONE. Otherwise idx <= idx-1.
  - No early exit. SHIFT always lasts exactly WIDTH cycles.
- DONE (one cycle):
  - done=1, busy=0, bit_valid=0.
  - eq/gt/lt <= final accumulator values (last-bit update included) at the DONE entry edge, so they are visible in the same cycle done is high.
  - start=1 in DONE is accepted with identical IDLE semantics (back-to-back comparison); otherwise state -> IDLE.
- Latency: start sampled at edge N.
  - bit_valid is high for cycles N+1 .. N+WIDTH.
  - done is high in cycle N+WIDTH+1.
  - Throughput is one comparison per WIDTH+1 cycles.
- Result hold: eq/gt/lt keep their last values through IDLE and through the next SHIFT. They change only at the next DONE or on reset.
- Invariant: after the first DONE, exactly one of eq/gt/lt is 1.
- start while in SHIFT is ignored: no restart and no relatch.
- a/b changes during SHIFT have no effect.
- bit_a/bit_b/bit_idx are 0 whenever bit_valid=0.
- Reset mid-SHIFT aborts the comparison:
  - No done pulse.
  - eq/gt/lt are cleared to 0.
  - The next start behaves as from a fresh reset.
- Comparison is unsigned only. There is no arithmetic beyond the per-bit compare, and idx never wraps: the transition at idx=0 goes to DONE.

Test Plan:
- WIDTH=4, a=4'b0101, b=4'b0101, start one cycle: bit_valid for 4 cycles with bit_a=bit_b=0,1,0,1; done in cycle 5 with eq=1, gt=0, lt=0.
- a=4'b1001, b=4'b0110: decided at bit 3; done at cycle 5 (not earlier) with gt=1, eq=0, lt=0; bit stream a=1,0,0,1 and b=0,1,1,0.
- a=4'b0110, b=4'b0111: differs only at the LSB; done gives lt=1, eq=0, gt=0, confirming the last-bit update is captured.
- Pulse start again on the 2nd SHIFT cycle while also changing a/b: no effect; result matches the original operands; exactly one done pulse.
- Drive rst_n=0 for one edge during the 3rd SHIFT cycle: next cycle all outputs are 0 and the state is IDLE; no done pulse; a following start a=3, b=2 gives gt=1.
- Assert start in the DONE cycle with new operands a=2, b=2: first result done with its value, then bit_valid resumes on the next cycle and the second done gives eq=1; eq/gt/lt hold the first result until then.
